// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: write-back select codes, exception constants and
// commit-stage state encoding.
package cpu_pkg;

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_MEM  = 2'd1;
    localparam logic [1:0] WB_LINK = 2'd2;

    localparam logic [4:0] EXC_OVF = 5'd12;

    localparam logic [31:0] ERET_WORD  = 32'h4200_0018;
    localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;
    localparam logic [31:0] RESET_PC   = 32'h0000_3000;

    typedef enum logic {
        RUN     = 1'b0,
        HANDLER = 1'b1
    } state_e;

endpackage

// File: rtl/wb_mux.sv
// Write-back data select between ALU result, load data and link address.
module wb_mux
    import cpu_pkg::*;
(
    input  logic [1:0]  i_sel,
    input  logic [31:0] i_alu,
    input  logic [31:0] i_mem,
    input  logic [31:0] i_link,
    output logic [31:0] o_data
);

    always_comb begin
        o_data = i_alu;
        case (i_sel)
            WB_MEM:  o_data = i_mem;
            WB_LINK: o_data = i_link;
            default: o_data = i_alu;
        endcase
    end

endmodule

// File: rtl/wb_commit.sv
// Write-back / commit stage: register-file write port, jump and exception redirect,
// EXL/EPC/Cause tracking with ERET return, and a retired-instruction counter.
module wb_commit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = cpu_pkg::RESET_PC,
    parameter logic [31:0] EXC_VECTOR = cpu_pkg::EXC_VECTOR,
    parameter logic [31:0] ERET_WORD  = cpu_pkg::ERET_WORD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Wr_Jtarget,
    input  logic [31:0] Wr_ALUres,
    input  logic [31:0] Wr_dout,
    input  logic [31:0] Wr_instr,
    input  logic [31:0] Wr_pcadd4,
    input  logic [4:0]  Wr_Rw,
    input  logic        Wr_Overflow,
    input  logic [1:0]  Wr_MemtoReg,
    input  logic        Wr_RegWr,
    input  logic [2:0]  Wr_jump,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        Flush,
    output logic        pc_redirect,
    output logic [31:0] pc_target,
    output logic [31:0] epc,
    output logic [4:0]  cause,
    output logic        exl,
    output logic [31:0] retire_cnt
);

    state_e      r_state;
    state_e      w_state_nxt;
    logic [31:0] r_epc;
    logic [4:0]  r_cause;
    logic [31:0] r_retire_cnt;

    logic        w_bubble;
    logic        w_is_eret;
    logic        w_in_handler;
    logic        w_take_exc;
    logic        w_do_eret;
    logic        w_do_jump;
    logic        w_redirect;
    logic [31:0] w_target;
    logic        w_retire;

    assign w_bubble     = (Wr_instr == 32'd0);
    assign w_is_eret    = (Wr_instr == ERET_WORD);
    assign w_in_handler = (r_state == HANDLER);

    // No nested exceptions: overflow inside the handler only suppresses the write.
    assign w_take_exc = ~w_in_handler & Wr_Overflow & ~w_bubble;
    assign w_do_eret  = w_in_handler & w_is_eret;
    // ERET outside the handler is a no-op, so an ERET word never acts as a jump.
    assign w_do_jump  = ~w_bubble & ~w_is_eret & ~w_take_exc & (Wr_jump != 3'd0);
    assign w_retire   = ~w_bubble & ~w_take_exc;

    always_comb begin
        w_state_nxt = r_state;
        w_redirect  = 1'b0;
        w_target    = 32'd0;
        if (w_take_exc) begin
            w_redirect  = 1'b1;
            w_target    = EXC_VECTOR;
            w_state_nxt = HANDLER;
        end else if (w_do_eret) begin
            w_redirect  = 1'b1;
            w_target    = r_epc;
            w_state_nxt = RUN;
        end else if (w_do_jump) begin
            w_redirect  = 1'b1;
            w_target    = Wr_Jtarget;
        end
        if (rst) begin
            w_redirect = 1'b0;
            w_target   = 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= RUN;
            r_epc        <= 32'd0;
            r_cause      <= 5'd0;
            r_retire_cnt <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_take_exc) begin
                r_epc   <= Wr_pcadd4 - 32'd4;
                r_cause <= EXC_OVF;
            end else if (w_do_eret) begin
                r_cause <= 5'd0;
            end
            if (w_retire) begin
                r_retire_cnt <= r_retire_cnt + 32'd1;
            end
        end
    end

    // Vectors and the bubble PC must be word aligned for epc = pcadd4 - 4 to hold.
    always_comb begin
        assert ((RESET_PC[1:0] == 2'b00) && (EXC_VECTOR[1:0] == 2'b00));
    end

    wb_mux u_wb_mux (
        .i_sel  (Wr_MemtoReg),
        .i_alu  (Wr_ALUres),
        .i_mem  (Wr_dout),
        .i_link (Wr_pcadd4),
        .o_data (rf_wdata)
    );

    // Any overflow, taken or not, blocks the write; ERET never writes.
    assign rf_we       = Wr_RegWr & ~Wr_Overflow & ~w_is_eret & (Wr_Rw != 5'd0) & ~rst;
    assign rf_waddr    = Wr_Rw;
    assign Flush       = w_redirect;
    assign pc_redirect = w_redirect;
    assign pc_target   = w_target;

    assign epc        = r_epc;
    assign cause      = r_cause;
    assign exl        = w_in_handler;
    assign retire_cnt = r_retire_cnt;

endmodule

// File: tb/tb_wb_commit.sv
// Randomized self-checking bench for wb_commit against a rule-level commit model.
module tb_wb_commit;

    localparam logic [31:0] ERET = 32'h4200_0018;
    localparam logic [31:0] VEC  = 32'h0000_4180;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] Wr_Jtarget, Wr_ALUres, Wr_dout, Wr_instr, Wr_pcadd4;
    logic [4:0]  Wr_Rw;
    logic        Wr_Overflow;
    logic [1:0]  Wr_MemtoReg;
    logic        Wr_RegWr;
    logic [2:0]  Wr_jump;
    logic        rf_we, Flush, pc_redirect, exl;
    logic [4:0]  rf_waddr, cause;
    logic [31:0] rf_wdata, pc_target, epc, retire_cnt;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Architectural model state
    bit          m_exl   = 1'b0;
    logic [31:0] m_epc   = 32'd0;
    logic [4:0]  m_cause = 5'd0;
    logic [31:0] m_cnt   = 32'd0;

    wb_commit dut (
        .clk         (clk),
        .rst         (rst),
        .Wr_Jtarget  (Wr_Jtarget),
        .Wr_ALUres   (Wr_ALUres),
        .Wr_dout     (Wr_dout),
        .Wr_instr    (Wr_instr),
        .Wr_pcadd4   (Wr_pcadd4),
        .Wr_Rw       (Wr_Rw),
        .Wr_Overflow (Wr_Overflow),
        .Wr_MemtoReg (Wr_MemtoReg),
        .Wr_RegWr    (Wr_RegWr),
        .Wr_jump     (Wr_jump),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .Flush       (Flush),
        .pc_redirect (pc_redirect),
        .pc_target   (pc_target),
        .epc         (epc),
        .cause       (cause),
        .exl         (exl),
        .retire_cnt  (retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", tag, obs, exp);
    endtask

    task automatic set_bubble();
        Wr_Jtarget  = '0;
        Wr_ALUres   = '0;
        Wr_dout     = '0;
        Wr_instr    = '0;
        Wr_pcadd4   = '0;
        Wr_Rw       = '0;
        Wr_Overflow = 1'b0;
        Wr_MemtoReg = '0;
        Wr_RegWr    = 1'b0;
        Wr_jump     = '0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom | 32'd1;
        if (w == ERET) w = 32'd1;
        return w;
    endfunction

    // Called just after a rising edge with inputs already driven.
    task automatic step();
        bit          nonbub, exc, ret, jmp, redir, we;
        logic [31:0] tgt, wdata;
        #2;
        nonbub = (Wr_instr != 32'd0);
        exc    = !m_exl && Wr_Overflow && nonbub;
        ret    = m_exl && (Wr_instr == ERET);
        jmp    = nonbub && (Wr_instr != ERET) && !exc && (Wr_jump != 0);
        redir  = (exc || ret || jmp) && !rst;
        tgt    = !redir ? 32'd0 : exc ? VEC : ret ? m_epc : Wr_Jtarget;
        we     = Wr_RegWr && !Wr_Overflow && (Wr_instr != ERET) && (Wr_Rw != 0) && !rst;
        wdata  = (Wr_MemtoReg == 2'd1) ? Wr_dout :
                 (Wr_MemtoReg == 2'd2) ? Wr_pcadd4 : Wr_ALUres;
        check_eq("rf_we", 32'(rf_we), 32'(we));
        if (we) begin
            check_eq("rf_waddr", 32'(rf_waddr), 32'(Wr_Rw));
            check_eq("rf_wdata", rf_wdata, wdata);
        end
        check_eq("flush", 32'(Flush), 32'(redir));
        check_eq("pc_redirect", 32'(pc_redirect), 32'(redir));
        if (redir) check_eq("pc_target", pc_target, tgt);
        @(posedge clk);
        #1;
        if (rst) begin
            m_exl = 0; m_epc = 0; m_cause = 0; m_cnt = 0;
        end else begin
            if (exc) begin
                m_exl = 1; m_epc = Wr_pcadd4 - 32'd4; m_cause = 5'd12;
            end else if (ret) begin
                m_exl = 0; m_cause = 5'd0;
            end
            if (nonbub && !exc) m_cnt = m_cnt + 32'd1;
        end
        check_eq("exl", 32'(exl), 32'(m_exl));
        check_eq("epc", epc, m_epc);
        check_eq("cause", 32'(cause), 32'(m_cause));
        check_eq("retire_cnt", retire_cnt, m_cnt);
    endtask

    initial begin
        int unsigned kind;
        rst = 1'b1;
        set_bubble();
        @(posedge clk);
        #1;
        step();
        step();
        check_eq("reset_cnt", retire_cnt, 32'd0);
        rst = 1'b0;

        // ADD
        Wr_instr = 32'h0109_5020; Wr_ALUres = 32'h55; Wr_Rw = 5'd8; Wr_RegWr = 1'b1;
        Wr_pcadd4 = 32'h3004;
        #1;
        check_eq("add_we", 32'(rf_we), 32'd1);
        check_eq("add_wdata", rf_wdata, 32'h55);
        step();
        check_eq("add_cnt", retire_cnt, 32'd1);

        // JAL with link
        Wr_instr = 32'h0C00_0C10; Wr_Jtarget = 32'h3040; Wr_pcadd4 = 32'h3014;
        Wr_MemtoReg = 2'd2; Wr_Rw = 5'd31; Wr_RegWr = 1'b1; Wr_jump = 3'd1;
        #1;
        check_eq("jal_wdata", rf_wdata, 32'h3014);
        check_eq("jal_target", pc_target, 32'h3040);
        step();
        set_bubble();
        step();

        // Overflow
        Wr_instr = 32'h0123_4020; Wr_pcadd4 = 32'h3024; Wr_RegWr = 1'b1; Wr_Rw = 5'd9;
        Wr_Overflow = 1'b1;
        #1;
        check_eq("ovf_target", pc_target, VEC);
        step();
        check_eq("ovf_epc", epc, 32'h3020);
        check_eq("ovf_cause", 32'(cause), 32'd12);
        set_bubble();
        step();
        Wr_instr = 32'h2008_0001; Wr_ALUres = 32'h7; Wr_Rw = 5'd8; Wr_RegWr = 1'b1;
        Wr_pcadd4 = 32'h4184;
        step();

        // ERET
        set_bubble();
        Wr_instr = ERET; Wr_pcadd4 = 32'h4188;
        #1;
        check_eq("eret_target", pc_target, 32'h3020);
        step();
        check_eq("eret_exl", 32'(exl), 32'd0);
        set_bubble();
        step();

        // Overflow and jump together: exception wins
        Wr_instr = 32'h1000_0004; Wr_jump = 3'd1; Wr_Jtarget = 32'h3100;
        Wr_Overflow = 1'b1; Wr_pcadd4 = 32'h3034;
        #1;
        check_eq("ovfjmp_target", pc_target, VEC);
        step();
        check_eq("ovfjmp_epc", epc, 32'h3030);

        // Reset while in HANDLER with retire_cnt = 7
        set_bubble();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 7; i++) begin
            set_bubble();
            Wr_instr = rand_instr(); Wr_pcadd4 = 32'h3000 + 32'(4 * (i + 1));
            step();
        end
        Wr_Overflow = 1'b1; Wr_pcadd4 = 32'h3020;
        step();
        check_eq("pre_rst_cnt", retire_cnt, 32'd7);
        set_bubble();
        Wr_instr = ERET;
        rst = 1'b1;
        #1;
        check_eq("rst_flush", 32'(Flush), 32'd0);
        step();
        rst = 1'b0;
        check_eq("rst_exl", 32'(exl), 32'd0);
        check_eq("rst_cnt", retire_cnt, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            set_bubble();
            rst = ($urandom_range(0, 99) < 2);
            kind = $urandom_range(0, 9);
            if (kind >= 2) begin
                Wr_instr    = rand_instr();
                Wr_ALUres   = $urandom;
                Wr_dout     = $urandom;
                Wr_Jtarget  = $urandom & 32'hFFFF_FFFC;
                Wr_pcadd4   = $urandom & 32'hFFFF_FFFC;
                Wr_Rw       = 5'($urandom);
                Wr_MemtoReg = 2'($urandom);
                Wr_RegWr    = 1'($urandom);
            end
            case (kind)
                4, 5: Wr_jump = 3'($urandom_range(1, 7));
                6: Wr_Overflow = 1'b1;
                7: begin Wr_Overflow = 1'b1; Wr_jump = 3'($urandom); end
                8: Wr_instr = ERET;
                default: ;
            endcase
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
